// File: rtl/fc_argmax.sv
// fc_argmax: streaming argmax over one frame of logits, with top-2 margin and a one-deep result buffer.
module fc_argmax #(
  parameter int OUTPUT_NUM = 10,
  parameter int DATA_W     = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     flush,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [3:0]               class_idx,
  output logic signed [DATA_W-1:0] max_logit,
  output logic signed [DATA_W-1:0] second_logit,
  output logic [DATA_W:0]          margin,
  output logic [15:0]              frame_cnt,
  output logic                     drop_pulse
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;
  localparam logic [3:0] LAST  = 4'(OUTPUT_NUM - 1);
  localparam logic signed [DATA_W-1:0] MINV = {1'b1, {(DATA_W-1){1'b0}}};

  if (OUTPUT_NUM < 2 || OUTPUT_NUM > 16) begin : g_bad_num
    $error("fc_argmax: OUTPUT_NUM must be within 2..16");
  end

  logic [0:0]               state_q, state_d;
  logic [3:0]               cnt_q, cnt_d, idx_q, idx_d, ridx_q, ridx_d;
  logic signed [DATA_W-1:0] max_q, max_d, sec_q, sec_d, rmax_q, rmax_d, rsec_q, rsec_d;
  logic signed [DATA_W-1:0] nmax, nsec;
  logic [3:0]               nidx;
  logic [DATA_W:0]          marg_q, marg_d;
  logic [15:0]              frame_cnt_q, frame_cnt_d;
  logic                     drop_q, drop_d;
  logic                     first, take, last, accept, load, gt_max, gt_sec;

  always_comb begin
    first       = cnt_q == 4'd0;
    take        = valid_in & ~flush;
    last        = take & (cnt_q == LAST);
    accept      = (state_q == HOLD) & out_ready;
    load        = last & ((state_q == EMPTY) | out_ready);
    drop_d      = last & (state_q == HOLD) & ~out_ready;
    gt_max      = data_in > max_q;
    gt_sec      = data_in > sec_q;
    nmax        = (first | gt_max) ? data_in : max_q;
    nsec        = first ? MINV : gt_max ? max_q : gt_sec ? data_in : sec_q;
    nidx        = first ? 4'd0 : gt_max ? cnt_q : idx_q;
    cnt_d       = flush ? 4'd0 : take ? (last ? 4'd0 : cnt_q + 4'd1) : cnt_q;
    max_d       = flush ? '0 : take ? nmax : max_q;
    sec_d       = flush ? '0 : take ? nsec : sec_q;
    idx_d       = flush ? 4'd0 : take ? nidx : idx_q;
    ridx_d      = load ? nidx : ridx_q;
    rmax_d      = load ? nmax : rmax_q;
    rsec_d      = load ? nsec : rsec_q;
    marg_d      = load ? ({nmax[DATA_W-1], nmax} - {nsec[DATA_W-1], nsec}) : marg_q;
    frame_cnt_d = frame_cnt_q + {15'd0, accept};
    state_d     = load ? HOLD : accept ? EMPTY : state_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      cnt_q       <= '0;
      idx_q       <= '0;
      max_q       <= '0;
      sec_q       <= '0;
      ridx_q      <= '0;
      rmax_q      <= '0;
      rsec_q      <= '0;
      marg_q      <= '0;
      frame_cnt_q <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      max_q       <= max_d;
      sec_q       <= sec_d;
      ridx_q      <= ridx_d;
      rmax_q      <= rmax_d;
      rsec_q      <= rsec_d;
      marg_q      <= marg_d;
      frame_cnt_q <= frame_cnt_d;
      drop_q      <= drop_d;
    end
  end

  assign out_valid    = state_q == HOLD;
  assign class_idx    = ridx_q;
  assign max_logit    = rmax_q;
  assign second_logit = rsec_q;
  assign margin       = marg_q;
  assign frame_cnt    = frame_cnt_q;
  assign drop_pulse   = drop_q;
endmodule

// File: tb/tb_fc_argmax.sv
// tb_fc_argmax: directed scenarios for fc_argmax with hand-computed expectations.
module tb_fc_argmax;
  localparam int W = 12;
  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                valid_in = 1'b0;
  logic signed [W-1:0] data_in = '0;
  logic                flush = 1'b0;
  logic                out_ready = 1'b0;
  logic                out_valid;
  logic [3:0]          class_idx;
  logic signed [W-1:0] max_logit, second_logit;
  logic [W:0]          margin;
  logic [15:0]         frame_cnt;
  logic                drop_pulse;
  int checks = 0;
  int errors = 0;
  int drops  = 0;
  int fr[10];

  fc_argmax #(.OUTPUT_NUM(10), .DATA_W(W)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .flush(flush),
    .out_ready(out_ready), .out_valid(out_valid), .class_idx(class_idx),
    .max_logit(max_logit), .second_logit(second_logit), .margin(margin),
    .frame_cnt(frame_cnt), .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (drop_pulse) drops++;
  endtask

  task automatic send(input int v, input int gap);
    valid_in = 1'b1;
    data_in  = W'(v);
    tick();
    valid_in = 1'b0;
    for (int i = 0; i < gap; i++) tick();
  endtask

  task automatic send_frame(input int n, input int gap);
    for (int i = 0; i < n; i++) send(fr[i], gap);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    drops = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0d exp 0", out_valid); end
    checks++; if (class_idx !== 4'd0) begin errors++; $display("FAIL reset_class_idx got %0d exp 0", class_idx); end
    checks++; if (max_logit !== 12'sd0 || second_logit !== 12'sd0) begin errors++; $display("FAIL reset_logits got %0d/%0d exp 0/0", max_logit, second_logit); end
    checks++; if (margin !== 13'd0 || frame_cnt !== 16'd0 || drop_pulse !== 1'b0) begin errors++; $display("FAIL reset_misc got margin %0d cnt %0d drop %0d exp 0", margin, frame_cnt, drop_pulse); end
  endtask

  task automatic test_basic();
    do_reset();
    out_ready = 1'b1;
    fr = '{5, -3, 100, 7, 100, 0, 0, 0, 0, -2048};
    send_frame(9, 1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %0d exp 0", out_valid); end
    send(fr[9], 0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0d exp 1", out_valid); end
    checks++; if (class_idx !== 4'd2) begin errors++; $display("FAIL basic_idx got %0d exp 2", class_idx); end
    checks++; if (max_logit !== 12'sd100) begin errors++; $display("FAIL basic_max got %0d exp 100", max_logit); end
    checks++; if (second_logit !== 12'sd100) begin errors++; $display("FAIL basic_second got %0d exp 100", second_logit); end
    checks++; if (margin !== 13'd0) begin errors++; $display("FAIL basic_margin got %0d exp 0", margin); end
    tick();
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL basic_frame_cnt got %0d exp 1", frame_cnt); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_after got %0d exp 0", out_valid); end
  endtask

  task automatic test_all_min();
    do_reset();
    out_ready = 1'b1;
    fr = '{-2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048};
    send_frame(10, 0);
    checks++; if (out_valid !== 1'b1 || class_idx !== 4'd0) begin errors++; $display("FAIL allmin_idx got valid %0d idx %0d exp 1/0", out_valid, class_idx); end
    checks++; if (max_logit !== -12'sd2048 || second_logit !== -12'sd2048) begin errors++; $display("FAIL allmin_logits got %0d/%0d exp -2048/-2048", max_logit, second_logit); end
    checks++; if (margin !== 13'd0) begin errors++; $display("FAIL allmin_margin got %0d exp 0", margin); end
  endtask

  task automatic test_drop();
    do_reset();
    fr = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    send_frame(10, 0);
    checks++; if (out_valid !== 1'b1 || class_idx !== 4'd9 || margin !== 13'd1) begin errors++; $display("FAIL drop_first got valid %0d idx %0d margin %0d exp 1/9/1", out_valid, class_idx, margin); end
    for (int i = 0; i < 20; i++) tick();
    checks++; if (out_valid !== 1'b1 || class_idx !== 4'd9 || max_logit !== 12'sd9) begin errors++; $display("FAIL drop_hold got valid %0d idx %0d max %0d exp 1/9/9", out_valid, class_idx, max_logit); end
    fr = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    send_frame(10, 0);
    checks++; if (drop_pulse !== 1'b1) begin errors++; $display("FAIL drop_pulse_now got %0d exp 1", drop_pulse); end
    tick();
    tick();
    checks++; if (drops !== 1) begin errors++; $display("FAIL drop_count got %0d exp 1", drops); end
    checks++; if (class_idx !== 4'd9 || margin !== 13'd1 || frame_cnt !== 16'd0) begin errors++; $display("FAIL drop_kept got idx %0d margin %0d cnt %0d exp 9/1/0", class_idx, margin, frame_cnt); end
    out_ready = 1'b1;
    tick();
    checks++; if (frame_cnt !== 16'd1 || out_valid !== 1'b0) begin errors++; $display("FAIL drop_accept got cnt %0d valid %0d exp 1/0", frame_cnt, out_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b1;
    fr = '{50, 60, 70, 80, 0, 0, 0, 0, 0, 0};
    send_frame(4, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    fr = '{-1, -1, -1, -1, -1, -1, 2047, -1, -1, -1};
    send_frame(10, 0);
    checks++; if (out_valid !== 1'b1 || class_idx !== 4'd6) begin errors++; $display("FAIL flush_idx got valid %0d idx %0d exp 1/6", out_valid, class_idx); end
    checks++; if (max_logit !== 12'sd2047 || second_logit !== -12'sd1) begin errors++; $display("FAIL flush_logits got %0d/%0d exp 2047/-1", max_logit, second_logit); end
    checks++; if (margin !== 13'd2048) begin errors++; $display("FAIL flush_margin got %0d exp 2048", margin); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    fr = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    send_frame(10, 0);
    fr = '{0, 0, 0, 500, 0, 0, 0, 0, 0, 0};
    send_frame(9, 0);
    checks++; if (class_idx !== 4'd9 || frame_cnt !== 16'd0) begin errors++; $display("FAIL b2b_before got idx %0d cnt %0d exp 9/0", class_idx, frame_cnt); end
    out_ready = 1'b1;
    send(fr[9], 0);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %0d exp 1", out_valid); end
    checks++; if (class_idx !== 4'd3 || max_logit !== 12'sd500 || margin !== 13'd500) begin errors++; $display("FAIL b2b_new got idx %0d max %0d margin %0d exp 3/500/500", class_idx, max_logit, margin); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL b2b_frame_cnt got %0d exp 1", frame_cnt); end
    tick();
    checks++; if (drops !== 0 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_nodrop got drops %0d valid %0d exp 0/1", drops, out_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b1;
    fr = '{1000, 1000, 1000, 1000, 1000, 0, 0, 0, 0, 0};
    send_frame(5, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fr = '{-5, -2, 1, 4, 300, 10, 13, 16, 19, 22};
    send_frame(9, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_early got %0d exp 0", out_valid); end
    send(fr[9], 0);
    checks++; if (out_valid !== 1'b1 || class_idx !== 4'd4) begin errors++; $display("FAIL rmid_idx got valid %0d idx %0d exp 1/4", out_valid, class_idx); end
    checks++; if (max_logit !== 12'sd300 || second_logit !== 12'sd22 || margin !== 13'd278) begin errors++; $display("FAIL rmid_vals got %0d/%0d/%0d exp 300/22/278", max_logit, second_logit, margin); end
    tick();
    tick();
    checks++; if (frame_cnt !== 16'd1 || out_valid !== 1'b0) begin errors++; $display("FAIL rmid_count got cnt %0d valid %0d exp 1/0", frame_cnt, out_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_min();
    test_drop();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fc_argmax.md
FC_ARGMAX -- requirements
Module: fc_argmax

Interface
REQ-001 SHALL have parameter OUTPUT_NUM, default 10, meaning number of logits per frame.
REQ-002 SHALL have parameter DATA_W, default 12, meaning signed logit width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port valid_in  in  1  one logit strobe; driven by fully_connected valid_out_fc.
REQ-006 SHALL have port data_in  in  DATA_W signed  logit; driven by fully_connected data_out.
REQ-007 SHALL have port flush  in  1  discards the partially collected frame.
REQ-008 SHALL have port out_ready  in  1  downstream accepts the result.
REQ-009 SHALL have port out_valid  out  1  result available.
REQ-010 SHALL have port class_idx  out  4  index of the maximum logit.
REQ-011 SHALL have port max_logit  out  DATA_W signed  maximum logit value.
REQ-012 SHALL have port second_logit  out  DATA_W signed  second-highest logit value.
REQ-013 SHALL have port margin  out  DATA_W+1 unsigned  max_logit minus second_logit.
REQ-014 SHALL have port frame_cnt  out  16  count of accepted results.
REQ-015 SHALL have port drop_pulse  out  1  one-cycle flag for a dropped frame.

Function
REQ-016 Logits SHALL arrive in index order 0..OUTPUT_NUM-1, one per valid_in cycle; gaps between strobes SHALL be tolerated.
REQ-017 A scan counter SHALL increment on each valid_in and wrap from OUTPUT_NUM-1 to 0.
REQ-018 Running max and second SHALL be updated in the same cycle as valid_in.
- index 0 loads max = data_in, idx = 0, second = -2^(DATA_W-1).
REQ-019 Update rule SHALL be:
- data_in > max: second = old max, max = data_in, idx = counter.
- else if data_in > second: second = data_in.
- strict compare, so a tie keeps the lower index as max and sets second equal to max.
REQ-020 Margin SHALL be computed at DATA_W+1 bits with no saturation.
REQ-021 The result registers SHALL load one cycle after the valid_in that carries index OUTPUT_NUM-1, with out_valid = 1 in that same cycle (latency 1).
REQ-022 The FSM SHALL have states EMPTY and HOLD.
- EMPTY -> HOLD on result load.
- HOLD -> EMPTY on out_valid & out_ready when no new load occurs that cycle.
REQ-023 Outputs SHALL be held stable while out_valid = 1 and out_ready = 0.
REQ-024 Collection of the next frame SHALL continue during HOLD.
REQ-025 If a frame completes while in HOLD without acceptance in the same cycle:
- the new result is discarded and the held result is kept;
- drop_pulse = 1 for one cycle;
- frame_cnt does not change.
REQ-026 If completion coincides with acceptance, the new result SHALL load, out_valid SHALL stay 1, and the FSM SHALL stay in HOLD.
REQ-027 frame_cnt SHALL increment on each out_valid & out_ready and wrap at 2^16.
REQ-028 flush SHALL take priority over valid_in in the same cycle.
- It zeroes the scan counter and the running max/second registers.
- It does not affect out_valid or the held result.
REQ-029 OUTPUT_NUM SHALL be limited to 2..16.

Reset
REQ-030 While rst = 1 the block SHALL set:
- out_valid = 0, class_idx = 0, max_logit = 0, second_logit = 0, margin = 0;
- frame_cnt = 0, drop_pulse = 0;
- scan counter = 0, FSM = EMPTY.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame; the first valid_in after reset is treated as index 0.

Verification
REQ-032 Scenario: logits 5,-3,100,7,100,0,0,0,0,-2048 with out_ready = 1 -> one cycle after the last strobe: out_valid = 1, class_idx = 2, max_logit = 100, second_logit = 100, margin = 0; frame_cnt = 1 one cycle later.
REQ-033 Scenario: all ten logits = -2048 -> class_idx = 0, max_logit = -2048, second_logit = -2048, margin = 0.
REQ-034 Scenario: logits 0..9 ascending, out_ready = 0 for 20 cycles, then a second frame 9..0 completes -> drop_pulse = 1 once, outputs stay class_idx = 9, margin = 1, frame_cnt = 0; after out_ready = 1, frame_cnt = 1 and out_valid = 0.
REQ-035 Scenario: flush after 4 logits, then a full frame with logit 2047 at index 6 and all others -1 -> class_idx = 6, second_logit = -1, margin = 2048.
REQ-036 Scenario: out_ready pulses in the same cycle as the next frame's load -> out_valid stays 1, new result is visible, frame_cnt increments by 1, and there is no drop.
REQ-037 Scenario: rst asserted after 5 logits, then a 10-logit frame -> exactly one result, equal to that of the post-reset frame.
